// File: rtl/superh16_pkg.sv
// Shared types and helpers for the rename-stage chain-depth tracker.
// Depth and latency widths live here and are used by every tracker file.
package superh16_pkg;

   localparam int DEPTH_BITS = 6;
   localparam int LAT_BITS   = 4;

   typedef logic [DEPTH_BITS-1:0] depth_t;

   localparam depth_t DEPTH_MAX = '1;

   typedef enum logic {
      CDT_IDLE,
      CDT_SWEEP
   } cdt_state_e;

   // Sum is formed one bit wider than a depth, so the top bit is the overflow.
   function automatic depth_t sat_add_depth(depth_t d, logic [LAT_BITS-1:0] lat);
      logic [DEPTH_BITS:0] sum;
      sum = {1'b0, d} + (DEPTH_BITS+1)'(lat);
      return sum[DEPTH_BITS] ? DEPTH_MAX : sum[DEPTH_BITS-1:0];
   endfunction

   function automatic logic depth_overflows(depth_t d, logic [LAT_BITS-1:0] lat);
      logic [DEPTH_BITS:0] sum;
      sum = {1'b0, d} + (DEPTH_BITS+1)'(lat);
      return sum[DEPTH_BITS];
   endfunction

endpackage

// File: rtl/superh16_cd_src_sel.sv
// Source-depth priority mux for one source operand of one slot:
// intra-group forward over writeback bypass over table read; unused source reads 0.
module superh16_cd_src_sel
   import superh16_pkg::*;
#(
   parameter int SLOTS    = 12,
   parameter int TAG_BITS = 9,
   parameter int WB_PORTS = 24
) (
   input  logic                                 src_valid,
   input  logic [TAG_BITS-1:0]                  src_tag,
   input  logic [SLOTS-1:0]                     fwd_en,
   input  logic [SLOTS-1:0][TAG_BITS-1:0]       fwd_tag,
   input  logic [SLOTS-1:0][DEPTH_BITS-1:0]     fwd_depth,
   input  logic [WB_PORTS-1:0]                  wb_valid,
   input  logic [WB_PORTS-1:0][TAG_BITS-1:0]    wb_tag,
   input  logic [WB_PORTS-1:0][DEPTH_BITS-1:0]  wb_depth,
   input  logic [DEPTH_BITS-1:0]                tbl_depth,
   output logic [DEPTH_BITS-1:0]                depth
);

   // Later assignments override earlier ones, so the last matching older slot wins.
   always_comb begin
      depth = tbl_depth;
      for (int k = 0; k < WB_PORTS; k++) begin
         if (wb_valid[k] && (wb_tag[k] == src_tag)) depth = wb_depth[k];
      end
      for (int i = 0; i < SLOTS; i++) begin
         if (fwd_en[i] && (fwd_tag[i] == src_tag)) depth = fwd_depth[i];
      end
      if (!src_valid) depth = '0;
   end

endmodule

// File: rtl/superh16_chain_depth_tracker.sv
// Rename-stage chain-depth tracker: depth = max(source depths) + latency, registered out.
// Optional saturation-event counter is built only when CHAIN_DEPTH_SAT_CNT_EN is defined.
//   state      | meaning
//   CDT_IDLE   | accepting rename groups, writeback updates the table
//   CDT_SWEEP  | clearing CLR_PER_CYC table entries per cycle after a flush
module superh16_chain_depth_tracker
   import superh16_pkg::*;
#(
   parameter int SLOTS       = 12,
   parameter int NUM_SRCS    = 3,
   parameter int NUM_REGS    = 384,
   parameter int TAG_BITS    = $clog2(NUM_REGS),
   parameter int WB_PORTS    = 24,
   parameter int CLR_PER_CYC = 32
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [SLOTS-1:0]                             slot_valid,
   input  logic [SLOTS-1:0][LAT_BITS-1:0]               slot_lat,
   input  logic [SLOTS-1:0][NUM_SRCS-1:0][TAG_BITS-1:0] src_tag,
   input  logic [SLOTS-1:0][NUM_SRCS-1:0]               src_valid,
   input  logic [SLOTS-1:0][TAG_BITS-1:0]               dst_tag,
   input  logic [SLOTS-1:0]                             dst_valid,
   output logic                                         out_valid,
   output logic [SLOTS-1:0][DEPTH_BITS-1:0]             out_depth,
   input  logic [WB_PORTS-1:0]                          wb_valid,
   input  logic [WB_PORTS-1:0][TAG_BITS-1:0]            wb_tag,
   input  logic [WB_PORTS-1:0][DEPTH_BITS-1:0]          wb_depth,
   input  logic                                         flush,
   output logic                                         sweep_busy,
   output logic [15:0]                                  sat_count
);

   localparam int SWEEP_CYC = NUM_REGS / CLR_PER_CYC;
   localparam int CNT_BITS  = (SWEEP_CYC > 1) ? $clog2(SWEEP_CYC) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(SWEEP_CYC - 1);

   cdt_state_e                      state_q, state_n;
   logic [CNT_BITS-1:0]             cnt_q, cnt_n;
   depth_t                          tbl [NUM_REGS];
   logic                            accept;
   logic [SLOTS-1:0][DEPTH_BITS-1:0] grp_depth;

`ifdef CHAIN_DEPTH_SAT_CNT_EN
   localparam int SAT_W = $clog2(SLOTS + 1);
   logic [SLOTS-1:0] sat_vec;
   logic [SAT_W-1:0] sat_inc;
   logic [16:0]      sat_sum;
   logic [15:0]      sat_q;
`endif

   assign in_ready   = (state_q == CDT_IDLE);
   assign sweep_busy = (state_q == CDT_SWEEP);
   // A group coinciding with flush is dropped: no table write and no out_valid.
   assign accept     = in_valid & in_ready & ~flush;

   for (genvar j = 0; j < SLOTS; j++) begin : g_slot
      logic [SLOTS-1:0]                 fwd_en;
      logic [SLOTS-1:0][DEPTH_BITS-1:0] fwd_depth;
      depth_t                           src_depth [NUM_SRCS];
      depth_t                           max_depth;
      depth_t                           slot_depth;

      for (genvar i = 0; i < SLOTS; i++) begin : g_fwd
         if (i < j) begin : g_older
            assign fwd_en[i]    = slot_valid[i] & dst_valid[i];
            assign fwd_depth[i] = g_slot[i].slot_depth;
         end else begin : g_younger
            assign fwd_en[i]    = 1'b0;
            assign fwd_depth[i] = '0;
         end
      end

      for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
         depth_t tbl_rd;
         assign tbl_rd = (32'(src_tag[j][s]) < NUM_REGS) ? tbl[src_tag[j][s]] : '0;

         superh16_cd_src_sel #(
            .SLOTS    (SLOTS),
            .TAG_BITS (TAG_BITS),
            .WB_PORTS (WB_PORTS)
         ) u_src_sel (
            .src_valid (src_valid[j][s]),
            .src_tag   (src_tag[j][s]),
            .fwd_en    (fwd_en),
            .fwd_tag   (dst_tag),
            .fwd_depth (fwd_depth),
            .wb_valid  (wb_valid),
            .wb_tag    (wb_tag),
            .wb_depth  (wb_depth),
            .tbl_depth (tbl_rd),
            .depth     (src_depth[s])
         );
      end

      always_comb begin
         max_depth = '0;
         for (int s = 0; s < NUM_SRCS; s++) begin
            if (src_depth[s] > max_depth) max_depth = src_depth[s];
         end
      end

      assign slot_depth   = slot_valid[j] ? sat_add_depth(max_depth, slot_lat[j]) : '0;
      assign grp_depth[j] = slot_depth;
`ifdef CHAIN_DEPTH_SAT_CNT_EN
      assign sat_vec[j]   = slot_valid[j] & depth_overflows(max_depth, slot_lat[j]);
`endif
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      case (state_q)
         CDT_IDLE: begin
            if (flush) begin
               state_n = CDT_SWEEP;
               cnt_n   = '0;
            end
         end
         CDT_SWEEP: begin
            if (flush) begin
               cnt_n = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_n = CDT_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: begin
            state_n = CDT_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CDT_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_depth <= '0;
      end else begin
         out_valid <= accept;
         if (accept) out_depth <= grp_depth;
      end
   end

   // Rename writes come after writeback so rename wins on a shared tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_REGS; e++) tbl[e] <= '0;
      end else if (state_q == CDT_IDLE) begin
         for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && (32'(wb_tag[k]) < NUM_REGS)) tbl[wb_tag[k]] <= wb_depth[k];
         end
         if (accept) begin
            for (int j = 0; j < SLOTS; j++) begin
               if (slot_valid[j] && dst_valid[j] && (32'(dst_tag[j]) < NUM_REGS))
                  tbl[dst_tag[j]] <= grp_depth[j];
            end
         end
      end else begin
         for (int e = 0; e < CLR_PER_CYC; e++)
            tbl[TAG_BITS'(int'(cnt_q) * CLR_PER_CYC + e)] <= '0;
      end
   end

`ifdef CHAIN_DEPTH_SAT_CNT_EN
   always_comb begin
      sat_inc = '0;
      for (int j = 0; j < SLOTS; j++) sat_inc = sat_inc + SAT_W'(sat_vec[j]);
      sat_sum = {1'b0, sat_q} + 17'(sat_inc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sat_q <= '0;
      else if (accept) sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   assign sat_count = sat_q;
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_superh16_chain_depth_tracker.sv
// Directed self-checking bench for superh16_chain_depth_tracker.
// Saturation-count expectations follow CHAIN_DEPTH_SAT_CNT_EN.
module tb_superh16_chain_depth_tracker;

   localparam int SLOTS = 12, NUM_SRCS = 3, NUM_REGS = 384, TAG_BITS = 9;
   localparam int DEPTH_BITS = 6, LAT_BITS = 4, WB_PORTS = 24, CLR_PER_CYC = 32;
`ifdef CHAIN_DEPTH_SAT_CNT_EN
   localparam int SAT_ON = 1;
`else
   localparam int SAT_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, flush, sweep_busy;
   logic [SLOTS-1:0]                             slot_valid, dst_valid;
   logic [SLOTS-1:0][LAT_BITS-1:0]               slot_lat;
   logic [SLOTS-1:0][NUM_SRCS-1:0][TAG_BITS-1:0] src_tag;
   logic [SLOTS-1:0][NUM_SRCS-1:0]               src_valid;
   logic [SLOTS-1:0][TAG_BITS-1:0]               dst_tag;
   logic [SLOTS-1:0][DEPTH_BITS-1:0]             out_depth;
   logic [WB_PORTS-1:0]                          wb_valid;
   logic [WB_PORTS-1:0][TAG_BITS-1:0]            wb_tag;
   logic [WB_PORTS-1:0][DEPTH_BITS-1:0]          wb_depth;
   logic [15:0]                                  sat_count;

   int errors = 0;
   int checks = 0;

   superh16_chain_depth_tracker #(
      .SLOTS(SLOTS), .NUM_SRCS(NUM_SRCS), .NUM_REGS(NUM_REGS), .TAG_BITS(TAG_BITS),
      .WB_PORTS(WB_PORTS), .CLR_PER_CYC(CLR_PER_CYC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .slot_valid(slot_valid), .slot_lat(slot_lat), .src_tag(src_tag), .src_valid(src_valid),
      .dst_tag(dst_tag), .dst_valid(dst_valid), .out_valid(out_valid), .out_depth(out_depth),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_depth(wb_depth), .flush(flush),
      .sweep_busy(sweep_busy), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      in_valid = 0; flush = 0;
      slot_valid = '0; slot_lat = '0; src_tag = '0; src_valid = '0;
      dst_tag = '0; dst_valid = '0; wb_valid = '0; wb_tag = '0; wb_depth = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send();
      in_valid = 1; step(); in_valid = 0;
   endtask

   task automatic read_tag(input int t, output logic [DEPTH_BITS-1:0] d);
      clear_inputs();
      slot_valid[0] = 1; src_tag[0][0] = t[TAG_BITS-1:0]; src_valid[0][0] = 1;
      send();
      d = out_depth[0];
      clear_inputs();
   endtask

   task automatic wb_write(input int t, input int v);
      clear_inputs();
      wb_valid[0] = 1; wb_tag[0] = t[TAG_BITS-1:0]; wb_depth[0] = v[DEPTH_BITS-1:0];
      step();
      clear_inputs();
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs();
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (out_depth !== '0) begin errors++; $display("FAIL reset_out_depth: got %0h expected 0", out_depth); end
      checks++; if (sweep_busy !== 1'b0) begin errors++; $display("FAIL reset_sweep_busy: got %0b expected 0", sweep_busy); end
      checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
      @(negedge clk); rst = 0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [DEPTH_BITS-1:0] d;
      clear_inputs();
      slot_valid[0] = 1; slot_lat[0] = 3; src_tag[0][0] = 5; src_valid[0][0] = 1;
      dst_tag[0] = 9; dst_valid[0] = 1;
      send();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
      checks++; if (out_depth[0] !== 6'd3) begin errors++; $display("FAIL basic_depth: got %0d expected 3", out_depth[0]); end
      clear_inputs(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0b expected 0", out_valid); end
      checks++; if (out_depth[0] !== 6'd3) begin errors++; $display("FAIL basic_hold: got %0d expected 3", out_depth[0]); end
      read_tag(9, d);
      checks++; if (d !== 6'd3) begin errors++; $display("FAIL basic_table9: got %0d expected 3", d); end
   endtask

   task automatic test_chain();
      logic [DEPTH_BITS-1:0] d;
      logic [DEPTH_BITS-1:0] exp [SLOTS];
      clear_inputs();
      slot_valid[2:0] = 3'b111; slot_lat[0] = 4; slot_lat[1] = 4; slot_lat[2] = 4;
      dst_tag[0] = 10; dst_valid[0] = 1;
      src_tag[1][0] = 10; src_valid[1][0] = 1; src_tag[1][1] = 5; src_valid[1][1] = 1;
      dst_tag[1] = 11; dst_valid[1] = 1;
      src_tag[2][2] = 11; src_valid[2][2] = 1; dst_tag[2] = 12; dst_valid[2] = 1;
      slot_lat[5] = 7; src_tag[5][0] = 10; src_valid[5][0] = 1;
      for (int j = 0; j < SLOTS; j++) exp[j] = '0;
      exp[0] = 4; exp[1] = 8; exp[2] = 12;
      send();
      for (int j = 0; j < SLOTS; j++) begin
         checks++;
         if (out_depth[j] !== exp[j]) begin errors++; $display("FAIL chain_slot%0d: got %0d expected %0d", j, out_depth[j], exp[j]); end
      end
      read_tag(12, d);
      checks++; if (d !== 6'd12) begin errors++; $display("FAIL chain_table12: got %0d expected 12", d); end
   endtask

   task automatic test_wb_bypass();
      logic [DEPTH_BITS-1:0] d;
      wb_write(20, 2);
      read_tag(20, d);
      checks++; if (d !== 6'd2) begin errors++; $display("FAIL wb_table20: got %0d expected 2", d); end
      clear_inputs();
      slot_valid[0] = 1; slot_lat[0] = 1; src_tag[0][0] = 20; src_valid[0][0] = 1;
      wb_valid[3] = 1; wb_tag[3] = 20; wb_depth[3] = 30;
      wb_valid[7] = 1; wb_tag[7] = 21; wb_depth[7] = 50;
      send();
      checks++; if (out_depth[0] !== 6'd31) begin errors++; $display("FAIL wb_bypass: got %0d expected 31", out_depth[0]); end
      clear_inputs();
      slot_valid[1:0] = 2'b11; slot_lat[0] = 5; dst_tag[0] = 20; dst_valid[0] = 1;
      slot_lat[1] = 1; src_tag[1][1] = 20; src_valid[1][1] = 1;
      wb_valid[3] = 1; wb_tag[3] = 20; wb_depth[3] = 30;
      send();
      checks++; if (out_depth[1] !== 6'd6) begin errors++; $display("FAIL fwd_over_wb: got %0d expected 6", out_depth[1]); end
      read_tag(20, d);
      checks++; if (d !== 6'd5) begin errors++; $display("FAIL rename_over_wb: got %0d expected 5", d); end
   endtask

   task automatic test_saturation();
      wb_write(30, 62);
      clear_inputs();
      slot_valid[0] = 1; slot_lat[0] = 5; src_tag[0][0] = 30; src_valid[0][0] = 1;
      send();
      checks++; if (out_depth[0] !== 6'd63) begin errors++; $display("FAIL sat_clamp: got %0d expected 63", out_depth[0]); end
      checks++; if (sat_count !== 16'(SAT_ON)) begin errors++; $display("FAIL sat_count1: got %0d expected %0d", sat_count, SAT_ON); end
      clear_inputs();
      slot_valid[4:0] = 5'b10111;
      for (int j = 0; j < 5; j++) begin src_tag[j][1] = 30; src_valid[j][1] = 1; end
      slot_lat[0] = 5; slot_lat[1] = 2; slot_lat[2] = 1; slot_lat[3] = 15; slot_lat[4] = 0;
      send();
      checks++; if (out_depth[0] !== 6'd63) begin errors++; $display("FAIL sat_s0: got %0d expected 63", out_depth[0]); end
      checks++; if (out_depth[1] !== 6'd63) begin errors++; $display("FAIL sat_s1: got %0d expected 63", out_depth[1]); end
      checks++; if (out_depth[2] !== 6'd63) begin errors++; $display("FAIL sat_edge: got %0d expected 63", out_depth[2]); end
      checks++; if (out_depth[3] !== 6'd0) begin errors++; $display("FAIL sat_invalid: got %0d expected 0", out_depth[3]); end
      checks++; if (out_depth[4] !== 6'd62) begin errors++; $display("FAIL sat_lat0: got %0d expected 62", out_depth[4]); end
      checks++; if (sat_count !== 16'(3 * SAT_ON)) begin errors++; $display("FAIL sat_count3: got %0d expected %0d", sat_count, 3 * SAT_ON); end
   endtask

   task automatic test_back_to_back();
      logic [DEPTH_BITS-1:0] d;
      clear_inputs();
      slot_valid[0] = 1; slot_lat[0] = 2; dst_tag[0] = 70; dst_valid[0] = 1;
      in_valid = 1; step();
      checks++; if (out_valid !== 1'b1 || out_depth[0] !== 6'd2) begin errors++; $display("FAIL b2b_first: got valid=%0b depth=%0d expected valid=1 depth=2", out_valid, out_depth[0]); end
      slot_valid[1:0] = 2'b11; slot_lat[0] = 3; src_tag[0][0] = 70; src_valid[0][0] = 1;
      dst_tag[0] = 71; slot_lat[1] = 6; dst_tag[1] = 71; dst_valid[1] = 1;
      step();
      checks++; if (out_valid !== 1'b1 || out_depth[0] !== 6'd5) begin errors++; $display("FAIL b2b_second: got valid=%0b depth=%0d expected valid=1 depth=5", out_valid, out_depth[0]); end
      checks++; if (out_depth[1] !== 6'd6) begin errors++; $display("FAIL b2b_slot1: got %0d expected 6", out_depth[1]); end
      clear_inputs();
      read_tag(71, d);
      checks++; if (d !== 6'd6) begin errors++; $display("FAIL dup_dst_high_slot: got %0d expected 6", d); end
   endtask

   task automatic test_flush();
      logic [DEPTH_BITS-1:0] d;
      int tags [11] = '{9, 10, 11, 12, 20, 30, 40, 60, 70, 71, 383};
      int busy;
      int bad_ready;
      wb_write(383, 17);
      clear_inputs();
      slot_valid[0] = 1; slot_lat[0] = 7; dst_tag[0] = 40; dst_valid[0] = 1;
      in_valid = 1; flush = 1;
      step();
      clear_inputs();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got out_valid=%0b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0 || sweep_busy !== 1'b1) begin errors++; $display("FAIL flush_enter: got ready=%0b busy=%0b expected ready=0 busy=1", in_ready, sweep_busy); end
      busy = 1; bad_ready = 0;
      for (int n = 0; n < 40 && sweep_busy; n++) begin
         if (busy == 3) begin wb_valid[0] = 1; wb_tag[0] = 60; wb_depth[0] = 9; end
         else wb_valid = '0;
         step();
         if (in_ready !== !sweep_busy) bad_ready++;
         if (sweep_busy) busy++;
      end
      clear_inputs();
      checks++; if (busy !== 12) begin errors++; $display("FAIL sweep_len: got %0d expected 12", busy); end
      checks++; if (bad_ready !== 0) begin errors++; $display("FAIL sweep_ready: got %0d bad cycles expected 0", bad_ready); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_exit_ready: got %0b expected 1", in_ready); end
      for (int i = 0; i < 11; i++) begin
         read_tag(tags[i], d);
         checks++; if (d !== '0) begin errors++; $display("FAIL sweep_clear_tag%0d: got %0d expected 0", tags[i], d); end
      end
      wb_write(100, 7); wb_write(383, 8);
      clear_inputs(); flush = 1; step(); flush = 0;
      busy = 1;
      for (int n = 0; n < 40 && sweep_busy; n++) begin
         flush = (busy == 5);
         step();
         if (sweep_busy) busy++;
      end
      clear_inputs();
      checks++; if (busy !== 17) begin errors++; $display("FAIL reflush_len: got %0d expected 17", busy); end
      read_tag(100, d);
      checks++; if (d !== '0) begin errors++; $display("FAIL reflush_tag100: got %0d expected 0", d); end
      read_tag(383, d);
      checks++; if (d !== '0) begin errors++; $display("FAIL reflush_tag383: got %0d expected 0", d); end
   endtask

   task automatic test_reset_mid_sweep();
      logic [DEPTH_BITS-1:0] d;
      wb_write(300, 21);
      clear_inputs(); slot_valid[0] = 1; slot_lat[0] = 9; send(); clear_inputs();
      checks++; if (out_depth[0] !== 6'd9) begin errors++; $display("FAIL prereset_depth: got %0d expected 9", out_depth[0]); end
      flush = 1; step(); flush = 0;
      step(); step();
      rst = 1; #1;
      checks++; if (sweep_busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_rst: got busy=%0b valid=%0b expected 0 0", sweep_busy, out_valid); end
      checks++; if (out_depth[0] !== 6'd0) begin errors++; $display("FAIL async_rst_depth: got %0d expected 0", out_depth[0]); end
      step();
      @(negedge clk); rst = 0;
      step();
      checks++; if (in_ready !== 1'b1 || sweep_busy !== 1'b0) begin errors++; $display("FAIL post_rst: got ready=%0b busy=%0b expected 1 0", in_ready, sweep_busy); end
      read_tag(300, d);
      checks++; if (d !== '0) begin errors++; $display("FAIL post_rst_tag300: got %0d expected 0", d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chain();
      test_wb_bypass();
      test_saturation();
      test_back_to_back();
      test_flush();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
